// File: rtl/iter_divider.sv
// Radix-2 restoring divider: collects dividend/divisor on two valid/ready
// channels, iterates one quotient bit per cycle, and pulses {quotient, remainder}.
module iter_divider #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REM_W  = DATA_W + 1;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
        return (SIGNED && x[DATA_W-1]) ? DATA_W'(-x) : x;
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? DATA_W'(-x) : x;
    endfunction

    logic [1:0]        state_q, state_nxt;
    logic [DATA_W-1:0] dvd_q, dvd_nxt;      // raw dividend in IDLE, quotient shift register in BUSY
    logic [DATA_W-1:0] dvs_q, dvs_nxt;
    logic [REM_W-1:0]  rem_q, rem_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              quo_neg_q, quo_neg_nxt;
    logic              rem_neg_q, rem_neg_nxt;
    logic              dividend_tready_nxt, divisor_tready_nxt;
    logic              dout_tvalid_nxt;
    logic [63:0]       dout_tdata_nxt;

    logic              dvd_fire, dvs_fire;
    logic [DATA_W-1:0] op_dvd, op_dvs;
    logic [REM_W:0]    rem_sh, trial;
    logic              q_bit;
    logic [REM_W-1:0]  rem_upd;
    logic [DATA_W-1:0] quo_upd;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q                <= ST_IDLE;
            dvd_q                  <= '0;
            dvs_q                  <= '0;
            rem_q                  <= '0;
            cnt_q                  <= '0;
            quo_neg_q              <= 1'b0;
            rem_neg_q              <= 1'b0;
            s_axis_dividend_tready <= 1'b1;
            s_axis_divisor_tready  <= 1'b1;
            m_axis_dout_tvalid     <= 1'b0;
            m_axis_dout_tdata      <= '0;
        end else begin
            state_q                <= state_nxt;
            dvd_q                  <= dvd_nxt;
            dvs_q                  <= dvs_nxt;
            rem_q                  <= rem_nxt;
            cnt_q                  <= cnt_nxt;
            quo_neg_q              <= quo_neg_nxt;
            rem_neg_q              <= rem_neg_nxt;
            s_axis_dividend_tready <= dividend_tready_nxt;
            s_axis_divisor_tready  <= divisor_tready_nxt;
            m_axis_dout_tvalid     <= dout_tvalid_nxt;
            m_axis_dout_tdata      <= dout_tdata_nxt;
        end
    end

    // Next-state, operand capture and one restoring step per BUSY cycle
    always_comb begin
        state_nxt           = state_q;
        dvd_nxt             = dvd_q;
        dvs_nxt             = dvs_q;
        rem_nxt             = rem_q;
        cnt_nxt             = cnt_q;
        quo_neg_nxt         = quo_neg_q;
        rem_neg_nxt         = rem_neg_q;
        dividend_tready_nxt = s_axis_dividend_tready;
        divisor_tready_nxt  = s_axis_divisor_tready;
        dout_tvalid_nxt     = 1'b0;
        dout_tdata_nxt      = m_axis_dout_tdata;

        dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
        dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;
        op_dvd   = dvd_fire ? s_axis_dividend_tdata : dvd_q;
        op_dvs   = dvs_fire ? s_axis_divisor_tdata : dvs_q;

        rem_sh  = {rem_q, dvd_q[DATA_W-1]};
        trial   = rem_sh - {2'b00, dvs_q};
        q_bit   = ~trial[REM_W];
        rem_upd = q_bit ? REM_W'(trial) : REM_W'(rem_sh);
        quo_upd = {dvd_q[DATA_W-2:0], q_bit};

        case (state_q)
            ST_IDLE: begin
                if (dvd_fire) begin
                    dvd_nxt             = s_axis_dividend_tdata;
                    dividend_tready_nxt = 1'b0;
                end
                if (dvs_fire) begin
                    dvs_nxt            = s_axis_divisor_tdata;
                    divisor_tready_nxt = 1'b0;
                end
                if ((!s_axis_dividend_tready || dvd_fire) && (!s_axis_divisor_tready || dvs_fire)) begin
                    state_nxt   = ST_BUSY;
                    dvd_nxt     = mag(op_dvd);
                    dvs_nxt     = mag(op_dvs);
                    rem_nxt     = '0;
                    cnt_nxt     = '0;
                    quo_neg_nxt = SIGNED && (op_dvd[DATA_W-1] ^ op_dvs[DATA_W-1]);
                    rem_neg_nxt = SIGNED && op_dvd[DATA_W-1];
                end
            end
            ST_BUSY: begin
                rem_nxt = rem_upd;
                dvd_nxt = quo_upd;
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_nxt       = ST_DONE;
                    dout_tvalid_nxt = 1'b1;
                    dout_tdata_nxt  = {neg_if(quo_neg_q, quo_upd), neg_if(rem_neg_q, rem_upd[DATA_W-1:0])};
                end
            end
            ST_DONE: begin
                state_nxt           = ST_IDLE;
                dvd_nxt             = '0;
                dvs_nxt             = '0;
                dividend_tready_nxt = 1'b1;
                divisor_tready_nxt  = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: unsigned and signed instances share stimulus and are
// checked every cycle against a transaction-level model plus literal vectors.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] dvd_d, dvs_d;
    logic        dvd_v, dvs_v;
    logic        rdy_a [2];
    logic        rdy_b [2];
    logic        dout_v [2];
    logic [63:0] dout_t [2];

    always #5 clk = ~clk;

    iter_divider #(.SIGNED(1'b0)) u_divu (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tdata(dvd_d), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(rdy_a[0]),
        .s_axis_divisor_tdata(dvs_d), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(rdy_b[0]),
        .m_axis_dout_tdata(dout_t[0]), .m_axis_dout_tvalid(dout_v[0])
    );

    iter_divider #(.SIGNED(1'b1)) u_divs (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tdata(dvd_d), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(rdy_a[1]),
        .s_axis_divisor_tdata(dvs_d), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(rdy_b[1]),
        .m_axis_dout_tdata(dout_t[1]), .m_axis_dout_tvalid(dout_v[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, inst, cyc, act, exp);
        end
    endtask

    // Plain-arithmetic reference for {quotient, remainder}
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, lq, lr;
        if (b == 32'd0) return {(sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa - lq * sb;
        return {32'(lq), 32'(lr)};
    endfunction

    // Transaction-level model: operands held, start cycle of the division, expected result
    bit          m_init = 1'b0;
    bit          m_busy, m_have_a, m_have_b;
    logic [31:0] m_a, m_b;
    int          m_start;
    logic [63:0] m_pend [2];
    logic [63:0] m_exp [2];
    int          pulse_cnt = 0;

    always @(negedge clk) begin
        if (m_init) begin
            for (int i = 0; i < 2; i++) begin
                chk("dout_tvalid", i, 64'(dout_v[i]), 64'(m_busy && cyc == m_start + 33));
                chk("dividend_tready", i, 64'(rdy_a[i]), 64'(!m_busy && !m_have_a));
                chk("divisor_tready", i, 64'(rdy_b[i]), 64'(!m_busy && !m_have_b));
                chk("dout_tdata", i, dout_t[i], m_exp[i]);
            end
            if (dout_v[0] === 1'b1) pulse_cnt++;
        end
        if (!resetn) begin
            m_init   = 1'b1;
            m_busy   = 1'b0;
            m_have_a = 1'b0;
            m_have_b = 1'b0;
            m_exp[0] = '0;
            m_exp[1] = '0;
        end else if (m_init) begin
            if (m_busy) begin
                if (cyc == m_start + 32) begin
                    m_exp[0] = m_pend[0];
                    m_exp[1] = m_pend[1];
                end
                if (cyc == m_start + 33) begin
                    m_busy   = 1'b0;
                    m_have_a = 1'b0;
                    m_have_b = 1'b0;
                end
            end else begin
                if (dvd_v && !m_have_a) begin
                    m_have_a = 1'b1;
                    m_a      = dvd_d;
                end
                if (dvs_v && !m_have_b) begin
                    m_have_b = 1'b1;
                    m_b      = dvs_d;
                end
                if (m_have_a && m_have_b) begin
                    m_busy    = 1'b1;
                    m_start   = cyc;
                    m_pend[0] = ref_div(m_a, m_b, 1'b0);
                    m_pend[1] = ref_div(m_a, m_b, 1'b1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle valid pulses; divisor follows the dividend after gap cycles
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int gap, output int ha, output int hb);
        step();
        dvd_v = 1'b1;
        dvd_d = a;
        ha    = cyc;
        hb    = cyc;
        if (gap == 0) begin
            dvs_v = 1'b1;
            dvs_d = b;
        end
        step();
        dvd_v = 1'b0;
        dvd_d = 32'hDEAD_BEEF;
        if (gap == 0) begin
            dvs_v = 1'b0;
            dvs_d = 32'hBAAD_F00D;
        end else begin
            repeat (gap - 1) step();
            dvs_v = 1'b1;
            dvs_d = b;
            hb    = cyc;
            step();
            dvs_v = 1'b0;
            dvs_d = 32'hBAAD_F00D;
        end
    endtask

    task automatic wait_pulse(output int pc);
        pc = -1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (dout_v[0] === 1'b1) begin
                pc = cyc;
                break;
            end
        end
        chk("pulse_seen", 0, 64'(pc >= 0), 64'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          inst;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] pa [3];
    logic [31:0] pb [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ha, hb, pc, p0, k;
        int acc [2];
        int pls [2];
        logic [63:0] pdat [2];
        int na, np;

        vecs[0] = '{32'hFFFF_FFF9, 32'h0000_0002, 1, {32'hFFFF_FFFD, 32'hFFFF_FFFF}};
        vecs[1] = '{32'h0000_0007, 32'hFFFF_FFFE, 1, {32'hFFFF_FFFD, 32'h0000_0001}};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1, {32'h8000_0000, 32'h0000_0000}};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 0, {32'h0000_0000, 32'h8000_0000}};
        vecs[4] = '{32'h0000_1234, 32'h0000_0000, 0, {32'hFFFF_FFFF, 32'h0000_1234}};
        vecs[5] = '{32'hFFFF_FF00, 32'h0000_0000, 1, {32'h0000_0001, 32'hFFFF_FF00}};
        vecs[6] = '{32'hFFFF_FF00, 32'h0000_0000, 0, {32'hFFFF_FFFF, 32'hFFFF_FF00}};

        resetn = 1'b0;
        dvd_v  = 1'b0;
        dvs_v  = 1'b0;
        dvd_d  = '0;
        dvs_d  = '0;
        repeat (3) step();
        resetn = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_dividend_tready", i, 64'(rdy_a[i]), 64'd1);
            chk("rst_divisor_tready", i, 64'(rdy_b[i]), 64'd1);
            chk("rst_dout_tvalid", i, 64'(dout_v[i]), 64'd0);
            chk("rst_dout_tdata", i, dout_t[i], 64'd0);
        end

        // 100 / 7 with both operands in cycle 10
        while (cyc < 9) step();
        issue(32'd100, 32'd7, 0, ha, hb);
        wait_pulse(pc);
        chk("pulse_cycle", 0, 64'(pc), 64'd43);
        chk("udiv_100_7", 0, dout_t[0], {32'h0000_000E, 32'h0000_0002});
        chk("sdiv_100_7", 1, dout_t[1], {32'h0000_000E, 32'h0000_0002});
        @(negedge clk);
        chk("ready_again_cycle", 0, 64'(cyc), 64'd44);
        chk("ready_again", 0, 64'(rdy_a[0] && rdy_b[0]), 64'd1);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, 0, ha, hb);
            wait_pulse(pc);
            chk("vec_latency", i, 64'(pc - hb), 64'd33);
            chk("vec_result", i, dout_t[vecs[i].inst], vecs[i].exp);
        end

        // Divisor arrives four cycles after the dividend
        issue(32'hFFFF_FFF9, 32'h0000_0002, 4, ha, hb);
        wait_pulse(pc);
        chk("split_latency", 0, 64'(pc - ha), 64'd37);
        chk("split_result", 1, dout_t[1], {32'hFFFF_FFFD, 32'hFFFF_FFFF});

        // Reset pulse at iteration 10 abandons the division
        issue(32'h1234_5678, 32'h0000_0009, 0, ha, hb);
        repeat (9) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("midrst_tready", i, 64'(rdy_a[i] && rdy_b[i]), 64'd1);
            chk("midrst_tdata", i, dout_t[i], 64'd0);
        end
        p0 = pulse_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_no_pulse", 0, 64'(pulse_cnt - p0), 64'd0);

        // Both valids held high, new pair presented after each accept
        pa[0] = 32'd100;        pb[0] = 32'd7;
        pa[1] = 32'hFFFF_FFF9;  pb[1] = 32'h0000_0002;
        pa[2] = 32'h0000_5555;  pb[2] = 32'h0000_0003;
        step();
        k = 0;
        na = 0;
        np = 0;
        dvd_v = 1'b1; dvs_v = 1'b1;
        dvd_d = pa[0]; dvs_d = pb[0];
        for (int c = 0; c < 68; c++) begin
            logic fired;
            @(negedge clk);
            fired = rdy_a[0] && rdy_b[0];
            if (fired && na < 2) begin
                acc[na] = cyc;
                na++;
            end
            if (dout_v[0] === 1'b1 && np < 2) begin
                pls[np]  = cyc;
                pdat[np] = dout_t[0];
                np++;
            end
            step();
            if (fired && k < 2) begin
                k++;
                dvd_d = pa[k];
                dvs_d = pb[k];
            end
        end
        dvd_v = 1'b0;
        dvs_v = 1'b0;
        chk("b2b_accepts", 0, 64'(na), 64'd2);
        chk("b2b_pulses", 0, 64'(np), 64'd2);
        if (na == 2 && np == 2) begin
            chk("b2b_accept_gap", 0, 64'(acc[1] - acc[0]), 64'd34);
            chk("b2b_pulse0_lat", 0, 64'(pls[0] - acc[0]), 64'd33);
            chk("b2b_pulse1_lat", 0, 64'(pls[1] - acc[0]), 64'd67);
            chk("b2b_result0", 0, pdat[0], {32'h0000_000E, 32'h0000_0002});
            chk("b2b_result1", 0, pdat[1], {32'h7FFF_FFFC, 32'h0000_0001});
        end
        chk("b2b_signed_last", 1, dout_t[1], {32'hFFFF_FFFD, 32'hFFFF_FFFF});

        repeat (40) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
